// File: rtl/pixel_sequencer.sv
// pixel_sequencer: erase/expose/convert/row-read strobe sequencer for a pixel
// array and its ADC, with start/busy/done handshake, video mode and abort.
module pixel_sequencer #(
  parameter int unsigned ROWS           = 2,
  parameter int unsigned ERASE_CYCLES   = 5,
  parameter int unsigned CONVERT_CYCLES = 255,
  parameter int unsigned READ_CYCLES    = 5,
  parameter int unsigned EXP_W          = 8,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             continuous,
  input  logic             abort,
  input  logic [EXP_W-1:0] exp_time,
  output logic             erase,
  output logic             expose,
  output logic             convert,
  output logic [ROWS-1:0]  read,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_count
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ERASE   = 3'd1;
  localparam logic [2:0] EXPOSE  = 3'd2;
  localparam logic [2:0] CONVERT = 3'd3;
  localparam logic [2:0] READ    = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  // Phase counter must hold the longest phase, including the widest exposure.
  localparam int unsigned EXP_MAX = (32'd1 << EXP_W) - 32'd1;
  localparam int unsigned LEN_A   = (ERASE_CYCLES > CONVERT_CYCLES) ? ERASE_CYCLES : CONVERT_CYCLES;
  localparam int unsigned LEN_B   = (READ_CYCLES > EXP_MAX) ? READ_CYCLES : EXP_MAX;
  localparam int unsigned MAXLEN  = (LEN_A > LEN_B) ? LEN_A : LEN_B;
  localparam int unsigned CW      = $clog2(MAXLEN + 1);
  localparam int unsigned RW      = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [2:0]       state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [RW-1:0]    row, row_nxt;
  logic [EXP_W-1:0] exp_lat, exp_nxt;
  logic [EXP_W-1:0] exp_eff;
  logic [CW-1:0]    phase_len;
  logic             phase_end;
  logic             erase_nxt, expose_nxt, convert_nxt, busy_nxt, done_nxt;
  logic [ROWS-1:0]  read_nxt;

  // Zero exposure is promoted to one cycle so EXPOSE always occupies a cycle.
  assign exp_eff = (exp_time == '0) ? EXP_W'(1) : exp_time;

  // Length of the phase currently running; phase_end marks its last cycle.
  always_comb begin
    phase_len = CW'(1);
    case (state)
      ERASE:   phase_len = CW'(ERASE_CYCLES);
      EXPOSE:  phase_len = CW'(exp_lat);
      CONVERT: phase_len = CW'(CONVERT_CYCLES);
      READ:    phase_len = CW'(READ_CYCLES);
      default: phase_len = CW'(1);
    endcase
    phase_end = ((cnt + CW'(1)) == phase_len);
  end

  // Next-state, counters and Moore output decode of the next state.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    row_nxt   = row;
    exp_nxt   = exp_lat;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt = ERASE;
          cnt_nxt   = '0;
          exp_nxt   = exp_eff;
        end
      end
      ERASE, EXPOSE, CONVERT: begin
        if (phase_end) begin
          cnt_nxt = '0;
          row_nxt = '0;
          if (state == ERASE)       state_nxt = EXPOSE;
          else if (state == EXPOSE) state_nxt = CONVERT;
          else                      state_nxt = READ;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      READ: begin
        if (phase_end) begin
          cnt_nxt = '0;
          if (row == RW'(ROWS - 1)) begin
            state_nxt = DONE;
            row_nxt   = '0;
          end else begin
            row_nxt = row + RW'(1);
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DONE: begin
        cnt_nxt = '0;
        row_nxt = '0;
        if (continuous) begin
          state_nxt = ERASE;
          exp_nxt   = exp_eff;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        row_nxt   = '0;
      end
    endcase
    if (abort && (state != IDLE)) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      row_nxt   = '0;
    end

    erase_nxt   = (state_nxt == ERASE);
    expose_nxt  = (state_nxt == EXPOSE);
    convert_nxt = (state_nxt == CONVERT);
    read_nxt    = (state_nxt == READ) ? (ROWS'(1) << row_nxt) : '0;
    busy_nxt    = (state_nxt != IDLE);
    done_nxt    = (state_nxt == DONE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      row         <= '0;
      exp_lat     <= '0;
      erase       <= 1'b0;
      expose      <= 1'b0;
      convert     <= 1'b0;
      read        <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      row        <= row_nxt;
      exp_lat    <= exp_nxt;
      erase      <= erase_nxt;
      expose     <= expose_nxt;
      convert    <= convert_nxt;
      read       <= read_nxt;
      busy       <= busy_nxt;
      frame_done <= done_nxt;
      if (done_nxt) frame_count <= frame_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pixel_sequencer.sv
// tb_pixel_sequencer: directed checks of frame timing, exposure latching,
// video mode, abort and asynchronous reset.
module tb_pixel_sequencer;

  localparam int unsigned ROWS  = 2;
  localparam int unsigned EXP_W = 8;
  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             reset;
  logic             start;
  logic             continuous;
  logic             abort;
  logic [EXP_W-1:0] exp_time;
  logic             erase;
  logic             expose;
  logic             convert;
  logic [ROWS-1:0]  read;
  logic             busy;
  logic             frame_done;
  logic [CNT_W-1:0] frame_count;

  int errors;
  int checks;
  int count_ref;

  pixel_sequencer #(
    .ROWS(ROWS), .ERASE_CYCLES(5), .CONVERT_CYCLES(8), .READ_CYCLES(4),
    .EXP_W(EXP_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous),
    .abort(abort), .exp_time(exp_time), .erase(erase), .expose(expose),
    .convert(convert), .read(read), .busy(busy), .frame_done(frame_done),
    .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {erase,expose,convert,read[1],read[0],busy,frame_done} at edge k
  // after a start driven just after edge 0 (erase 5, convert 8, read 4x2).
  function automatic logic [6:0] exp_vec(input int k, input int e);
    logic er, ex, cv, r0, r1, b, d;
    er = (k >= 1) && (k <= 5);
    ex = (k >= 6) && (k <= 5 + e);
    cv = (k >= 6 + e) && (k <= 13 + e);
    r0 = (k >= 14 + e) && (k <= 17 + e);
    r1 = (k >= 18 + e) && (k <= 21 + e);
    d  = (k == 22 + e);
    b  = (k >= 1) && (k <= 22 + e);
    return {er, ex, cv, r1, r0, b, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; continuous = 1'b0; abort = 1'b0; exp_time = '0;
    #3;
    checks++;
    if ({erase, expose, convert, read, busy, frame_done} !== 7'b0 || frame_count !== '0) begin
      errors++;
      $display("FAIL reset_hold: outs=%b count=%0d expected 0", {erase, expose, convert, read, busy, frame_done}, frame_count);
    end
    tick(); tick();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({erase, expose, convert, read, busy, frame_done} !== 7'b0 || frame_count !== '0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: outs=%b count=%0d expected 0", i, {erase, expose, convert, read, busy, frame_done}, frame_count);
      end
    end
  endtask

  // One frame started after the current edge; exp_time switches to exp_mid
  // during EXPOSE and must not change this frame's timing.
  task automatic test_frame(input string name, input logic [EXP_W-1:0] exp_drive,
                            input logic [EXP_W-1:0] exp_mid, input int e_eff);
    logic [6:0] obs;
    logic [6:0] expv;
    exp_time = exp_drive;
    start    = 1'b1;
    for (int k = 1; k <= 23 + e_eff; k++) begin
      tick();
      if (k == 1) start = 1'b0;
      if (k == 7) exp_time = exp_mid;
      obs  = {erase, expose, convert, read, busy, frame_done};
      expv = exp_vec(k, e_eff);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL %s edge %0d: got %b expected %b", name, k, obs, expv);
      end
    end
    count_ref++;
    checks++;
    if (frame_count !== CNT_W'(count_ref)) begin
      errors++;
      $display("FAIL %s count: got %0d expected %0d", name, frame_count, count_ref);
    end
    exp_time = '0;
  endtask

  task automatic test_continuous();
    logic [6:0] obs;
    logic [6:0] expv;
    int dones;
    dones      = 0;
    exp_time   = 8'd3;
    continuous = 1'b1;
    start      = 1'b1;
    // Three frames of 25 busy cycles back to back, then idle.
    for (int k = 1; k <= 77; k++) begin
      tick();
      if (k == 1) start = 1'b0;
      if (k == 60) continuous = 1'b0;
      if (frame_done === 1'b1) dones++;
      obs  = {erase, expose, convert, read, busy, frame_done};
      expv = (k <= 75) ? exp_vec(((k - 1) % 25) + 1, 3) : 7'b0;
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL continuous edge %0d: got %b expected %b", k, obs, expv);
      end
    end
    checks++;
    if (dones != 3) begin
      errors++;
      $display("FAIL continuous_pulses: got %0d expected 3", dones);
    end
    count_ref += 3;
    checks++;
    if (frame_count !== CNT_W'(count_ref)) begin
      errors++;
      $display("FAIL continuous_count: got %0d expected %0d", frame_count, count_ref);
    end
  endtask

  task automatic test_abort();
    logic [6:0] obs;
    exp_time = 8'd4;
    start    = 1'b1;
    // convert occupies edges 10..17 for E=4; abort sampled at edge 13
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 1) start = 1'b0;
    end
    checks++;
    if (convert !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: convert=%b expected 1", convert);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({erase, expose, convert, read, busy, frame_done} !== 7'b0) begin
      errors++;
      $display("FAIL abort_edge: outs=%b expected 0", {erase, expose, convert, read, busy, frame_done});
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      obs = {erase, expose, convert, read, busy, frame_done};
      checks++;
      if (obs !== 7'b0) begin
        errors++;
        $display("FAIL abort_after cycle %0d: outs=%b expected 0", i, obs);
      end
    end
    checks++;
    if (frame_count !== CNT_W'(count_ref)) begin
      errors++;
      $display("FAIL abort_count: got %0d expected %0d", frame_count, count_ref);
    end
    // start with abort in IDLE must not launch a frame
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      obs = {erase, expose, convert, read, busy, frame_done};
      checks++;
      if (obs !== 7'b0) begin
        errors++;
        $display("FAIL start_abort cycle %0d: outs=%b expected 0", i, obs);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_time = 8'd2;
    start    = 1'b1;
    // read[1] occupies edges 20..23 for E=2
    for (int k = 1; k <= 21; k++) begin
      tick();
      if (k == 1) start = 1'b0;
    end
    checks++;
    if (read !== 2'b10 || frame_count !== CNT_W'(count_ref)) begin
      errors++;
      $display("FAIL async_pre: read=%b count=%0d expected 10 / %0d", read, frame_count, count_ref);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({erase, expose, convert, read, busy, frame_done} !== 7'b0 || frame_count !== '0) begin
      errors++;
      $display("FAIL async_reset: outs=%b count=%0d expected 0", {erase, expose, convert, read, busy, frame_done}, frame_count);
    end
    tick();
    reset = 1'b1;
    count_ref = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({erase, expose, convert, read, busy, frame_done} !== 7'b0 || frame_count !== '0) begin
        errors++;
        $display("FAIL async_after cycle %0d: outs=%b count=%0d expected 0", i, {erase, expose, convert, read, busy, frame_done}, frame_count);
      end
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    count_ref = 0;
    test_reset();
    test_frame("single_frame", 8'd10, 8'd10, 10);
    test_frame("exp_zero", 8'd0, 8'd0, 1);
    test_frame("exp_latch", 8'd6, 8'd200, 6);
    test_continuous();
    test_abort();
    test_async_reset();
    test_frame("post_reset", 8'd1, 8'd1, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pixel_sequencer.md
# pixel_sequencer

Parametrised pixel-array sequencer generating the erase, expose, convert and per-row read strobes for the pixel array and its ADC. It generalises the fixed two-read pixel state machine. It adds:
- row count, phase lengths and exposure-time width set by parameters;
- exposure time latched per frame from an input;
- a start/busy/done handshake, continuous (video) mode, abort, and a frame counter.

It sits between the camera control logic and the analog pixel array.

## Interface
- ROWS, default 2: number of read phases per frame (≥1).
- ERASE_CYCLES, default 5: erase phase length in clk cycles (≥1).
- CONVERT_CYCLES, default 255: convert phase length in clk cycles (≥1).
- READ_CYCLES, default 5: length of each row read phase in clk cycles (≥1).
- EXP_W, default 8: exposure-time width.
- CNT_W, default 16: frame counter width.

Ports:
- clk, in, 1: clock; all logic on rising edge.
- reset, in, 1: asynchronous, active-low reset (asserted when 0).
- start, in, 1: frame request, sampled only in IDLE.
- continuous, in, 1: 1 = start the next frame automatically after DONE.
- abort, in, 1: synchronous frame abort.
- exp_time, in, EXP_W: exposure length in cycles; 0 is treated as 1.
- erase, out, 1: erase strobe.
- expose, out, 1: expose strobe.
- convert, out, 1: convert strobe.
- read, out, ROWS: one-hot row read strobes; read[0] is read first.
- busy, out, 1: high in any state other than IDLE.
- frame_done, out, 1: one-cycle pulse on frame completion.
- frame_count, out, CNT_W: number of completed frames; wraps at 2^CNT_W.

## Operation
- States: IDLE, ERASE, EXPOSE, CONVERT, READ, DONE.
- All outputs are registered and Moore-decoded. At most one of erase, expose, convert or a read bit is high in any cycle.
- **Reset:** state = IDLE. erase, expose, convert, read, busy, frame_done and frame_count are all 0. The phase counter, row index and latched exposure are also 0.
- **IDLE:** when start=1 and abort=0, latch max(exp_time,1) and go to ERASE.
- **ERASE:** erase=1 for exactly ERASE_CYCLES cycles, then EXPOSE.
- **EXPOSE:** expose=1 for exactly the latched exposure count, then CONVERT. exp_time changes during a frame have no effect on that frame.
- **CONVERT:** convert=1 for exactly CONVERT_CYCLES cycles, then READ with row index 0.
- **READ:** read[row]=1 for READ_CYCLES cycles, then row increments. After row ROWS-1 completes, go to DONE.
- **DONE:** lasts one cycle; frame_done=1, busy=1, frame_count increments.
  - If continuous=1 in this cycle: re-latch exp_time and go to ERASE.
  - Otherwise go to IDLE.
- **Abort:** abort=1 in any non-IDLE state sends the block to IDLE on the next edge.
  - All strobes and busy are low from that edge.
  - No frame_done pulse; frame_count unchanged.
  - abort in IDLE is ignored. If abort and start are both high in IDLE, abort wins and the block stays in IDLE.
- **Start outside IDLE:** ignored.
- **Reset mid-frame:** the block returns immediately to the reset values.

## Timing
- Latency: start sampled at edge 0 → erase high from edge 1.
- Frame length in busy cycles: ERASE_CYCLES + E + CONVERT_CYCLES + ROWS·READ_CYCLES + 1, where E = max(exp_time,1).
- Phase boundaries are gap-free: the next strobe rises on the same edge the previous one falls.
- In continuous mode, erase rises on the edge after the DONE cycle; busy stays high throughout.
- frame_done and the frame_count update happen on the same edge, at entry to DONE.
- Counters in each phase run from 0 up to length-1 and are sized for the maximum of the phase parameters and 2^EXP_W-1.

## Test plan
Bench overrides: ROWS=2, ERASE_CYCLES=5, CONVERT_CYCLES=8, READ_CYCLES=4.
- **Reset values:** hold reset=0 → all outputs 0. Release reset with start=0 for 10 cycles → outputs remain 0.
- **Single frame:** exp_time=10, 1-cycle start at edge 0 →
  - erase high at edges 1–5, expose 6–15, convert 16–23, read[0] 24–27, read[1] 28–31;
  - frame_done high only at edge 32;
  - busy high at edges 1–32;
  - frame_count=1, then IDLE.
- **exp_time=0 and latching:** exp_time=0 → expose lasts exactly 1 cycle. Changing exp_time during EXPOSE → current frame length unchanged.
- **Continuous:** continuous=1, exp_time=3 → frames repeat with no idle gap and erase rising the edge after each frame_done. After 3 frame_done pulses, frame_count=3.
- **Abort:** abort during CONVERT → all strobes low and busy=0 on the next edge; no frame_done; frame_count unchanged. start and abort together in IDLE → no frame.
- **Async reset mid-read:** reset=0 during read[1] → outputs clear immediately without waiting for a clk edge; frame_count=0.
